fmlarb_ctl: RTL and testbench
=============================

# fmlarb_ctl

Multi-master arbiter for the 4x64 FML bus, sitting directly upstream of the HPDMC DDR controller's FML slave port. Grants one master at a time, forwards its address/strobe/direction to the controller, and returns the controller's early acknowledge to the granted master. Steers write data from the master whose write was last acknowledged. Broadcasts read data to all masters.

## Interface

**Parameters**
- `nmasters`, default 4: number of FML masters, 2..8.
- `fml_depth`, default 26: FML byte address width, matching the controller's `sdram_depth`.

**Ports**
- `sys_clk`, in, 1: system clock; all logic on the rising edge.
- `sys_rst_n`, in, 1: reset, synchronous, active-low.
- `m_adr`, in, nmasters*fml_depth: master addresses; master i at `[i*fml_depth +: fml_depth]`.
- `m_stb`, in, nmasters: master request strobes.
- `m_we`, in, nmasters: master write flags.
- `m_eack`, out, nmasters: per-master early acknowledge.
- `m_sel`, in, nmasters*8: master byte enables, 8 per master.
- `m_di`, in, nmasters*64: master write data, 64 per master.
- `m_do`, out, 64: read data, broadcast to all masters.
- `s_adr`, out, fml_depth: address to the controller.
- `s_stb`, out, 1: strobe to the controller.
- `s_we`, out, 1: write flag to the controller.
- `s_eack`, in, 1: early acknowledge from the controller.
- `s_sel`, out, 8: byte enables to the controller.
- `s_di`, out, 64: write data to the controller.
- `s_do`, in, 64: read data from the controller.

## Operation

**State machine:** two states, IDLE and GRANT, with registers `owner`, `wowner` and `rrptr` (each log2(nmasters) wide).

- **IDLE**
  - `s_stb` = 0.
  - If any `m_stb` is set, load `owner` with the arbitration winner and go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT**
  - `s_stb` = `m_stb[owner]`; `s_adr` and `s_we` are taken from master `owner` combinationally.
  - `m_eack[owner]` = `s_eack`; every other `m_eack` bit = 0.
  - On `s_eack` = 1:
    - return to IDLE;
    - set `rrptr` to (owner+1) mod nmasters;
    - if `m_we[owner]` = 1, set `wowner` to `owner`.
  - If `m_stb[owner]` drops without `s_eack` (aborted request): return to IDLE; `rrptr` and `wowner` are unchanged.

**Arbitration:** round-robin. Search starts at `rrptr` and takes the lowest index at or above `rrptr` that is requesting, wrapping past nmasters-1 to 0.

**Write data path:** `s_di` and `s_sel` always come from master `wowner`. The switch happens on the clock edge that ends the write-ack cycle, so the burst data beats (which follow the ack) come from the new writer.

**Read data path:** `m_do` = `s_do`, with no register. Each master tracks its own read latency.

**Address stability:** while in GRANT with `s_stb` high, `owner` does not change, so `s_adr` and `s_we` stay stable until the ack, as FML requires.

**Reset values:**
- state = IDLE, `owner` = 0, `wowner` = 0, `rrptr` = 0.
- `s_stb` = 0 and `m_eack` = 0 during reset and on the first cycle after it.

**Reset mid-operation:** abandons any pending grant; no ack is forwarded after reset is sampled.

## Timing

- Latency from `m_stb` rising (while in IDLE) to `s_stb` is 1 cycle.
- Back-to-back requests: after an ack there is one IDLE bubble cycle, so acks are at least 2 cycles apart.
- `s_eack` → `m_eack` is combinational, same cycle.
- `s_do` → `m_do` is combinational.
- Simultaneous requests from all masters are granted in rotation order starting at `rrptr`.
- With a single requester it is re-granted every 2 cycles.
- `s_eack` arriving while in IDLE is ignored; this is a controller protocol violation.

## Configuration

Macro `FMLARB_FIXED_PRIO_EN`:
- **Defined:** arbitration is fixed priority, lowest index wins, and `rrptr` is held at 0. Intended for video-refresh masters placed at index 0.
- **Undefined:** round-robin arbitration as described under Operation.

Both modes keep identical write-data steering and timing.

## Structure

- **Package `fmlarb_pkg`** holds:
  - FML constants: data width 64, byte-enable width 8, burst length 4;
  - the state enum `{IDLE, GRANT}`;
  - a function for the log2 index width.
- **Sub-module `fmlarb_rrsel`**, combinational: rotating priority picker.
  - Inputs: request vector, start pointer.
  - Outputs: winner index, any-request flag.
  - In fixed-priority mode the top level instantiates it with the pointer tied to 0.

## Test plan

1. **Reset:** hold `sys_rst_n` = 0 with all `m_stb` = 1 → `s_stb` = 0 and `m_eack` = 0; after release, master 0 is granted with `s_stb` = 1 at cycle 2.
2. **Round-robin:** with 4 masters all requesting and `s_eack` pulsed each time `s_stb` is high → grant order is 0, 1, 2, 3, 0, and each `m_eack[i]` is a single pulse coincident with `s_eack`.
3. **Write steering:** master 2 writes with `m_di[2]` = 64'hA5A5_0000_0000_0002, then master 1 reads → after master 2's ack, `s_di` equals master 2's data and stays there through master 1's read.
4. **Read broadcast:** drive `s_do` = 64'hDEAD_BEEF_0123_4567 → every master sees that value on `m_do` in the same cycle.
5. **Abort:** master 3 drops `m_stb` before any ack → arbiter returns to IDLE, `rrptr` is unchanged, and the next grant goes to the next requester.
6. **`FMLARB_FIXED_PRIO_EN` build:** masters 0 and 3 request continuously → master 0 wins every arbitration and master 3 is never granted.

Source files
------------

// File: rtl/fmlarb_pkg.sv
// rtl/fmlarb_pkg.sv - FML bus constants, arbiter state type and index-width helper.
package fmlarb_pkg;
   localparam int FML_DW    = 64;
   localparam int FML_SW    = 8;
   localparam int FML_BURST = 4;

   typedef enum logic {IDLE, GRANT} fmlarb_state_e;

   function automatic int fmlarb_iw(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/fmlarb_rrsel.sv
// rtl/fmlarb_rrsel.sv - rotating priority picker: lowest requester at or above i_ptr, wrapping.
module fmlarb_rrsel #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] i_req,
   input  logic [W-1:0] i_ptr,
   output logic [W-1:0] o_idx,
   output logic         o_any
);
   int w_j;

   // Scan from farthest to nearest offset so the nearest requester overwrites.
   always_comb begin
      o_idx = '0;
      o_any = 1'b0;
      w_j   = 0;
      for (int k = N - 1; k >= 0; k--) begin
         w_j = (int'(i_ptr) + k) % N;
         if (i_req[W'(w_j)]) begin
            o_idx = W'(w_j);
            o_any = 1'b1;
         end
      end
   end
endmodule

// File: rtl/fmlarb_ctl.sv
// rtl/fmlarb_ctl.sv - multi-master FML arbiter in front of the DDR controller slave port.
// FMLARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module fmlarb_ctl
   import fmlarb_pkg::*;
#(
   parameter int nmasters  = 4,
   parameter int fml_depth = 26
) (
   input  logic                          sys_clk,
   input  logic                          sys_rst_n,
   input  logic [nmasters*fml_depth-1:0] m_adr,
   input  logic [nmasters-1:0]           m_stb,
   input  logic [nmasters-1:0]           m_we,
   output logic [nmasters-1:0]           m_eack,
   input  logic [nmasters*FML_SW-1:0]    m_sel,
   input  logic [nmasters*FML_DW-1:0]    m_di,
   output logic [FML_DW-1:0]             m_do,
   output logic [fml_depth-1:0]          s_adr,
   output logic                          s_stb,
   output logic                          s_we,
   input  logic                          s_eack,
   output logic [FML_SW-1:0]             s_sel,
   output logic [FML_DW-1:0]             s_di,
   input  logic [FML_DW-1:0]             s_do
);
   localparam int W = fmlarb_iw(nmasters);

   fmlarb_state_e  r_state;
   logic [W-1:0]   r_owner;
   logic [W-1:0]   r_wowner;
   logic [W-1:0]   r_rrptr;
   logic [W-1:0]   w_ptr;
   logic [W-1:0]   w_next;
   logic [W-1:0]   w_win;
   logic           w_any;
   logic           w_grant;

`ifdef FMLARB_FIXED_PRIO_EN
   assign w_ptr  = '0;
   assign w_next = '0;
`else
   assign w_ptr  = r_rrptr;
   assign w_next = (r_owner == W'(nmasters - 1)) ? '0 : r_owner + W'(1);
`endif

   fmlarb_rrsel #(.N(nmasters), .W(W)) u_rrsel (
      .i_req (m_stb),
      .i_ptr (w_ptr),
      .o_idx (w_win),
      .o_any (w_any)
   );

   // Gating with reset keeps strobe and ack quiet before the first sampled edge.
   assign w_grant = sys_rst_n && (r_state == GRANT);
   assign s_stb   = w_grant && m_stb[r_owner];
   assign s_adr   = m_adr[int'(r_owner)*fml_depth +: fml_depth];
   assign s_we    = m_we[r_owner];
   assign s_di    = m_di[int'(r_wowner)*FML_DW +: FML_DW];
   assign s_sel   = m_sel[int'(r_wowner)*FML_SW +: FML_SW];
   assign m_do    = s_do;

   always_comb begin
      m_eack = '0;
      if (w_grant) m_eack[r_owner] = s_eack;
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_state  <= IDLE;
         r_owner  <= '0;
         r_wowner <= '0;
         r_rrptr  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_owner <= w_win;
                  r_state <= GRANT;
               end
            end
            GRANT: begin
               if (s_eack) begin
                  r_state <= IDLE;
                  r_rrptr <= w_next;
                  if (m_we[r_owner]) r_wowner <= r_owner;
               end else if (!m_stb[r_owner]) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fmlarb_ctl.sv
// tb/tb_fmlarb_ctl.sv - directed and randomized checks of fmlarb_ctl against a cycle model.
// FMLARB_FIXED_PRIO_EN switches the model and expected grant order to fixed priority.
module tb_fmlarb_ctl;
   localparam int NM = 4;
   localparam int FD = 26;

   logic              sys_clk = 1'b0;
   logic              sys_rst_n;
   logic [NM*FD-1:0]  m_adr;
   logic [NM-1:0]     m_stb;
   logic [NM-1:0]     m_we;
   logic [NM-1:0]     m_eack;
   logic [NM*8-1:0]   m_sel;
   logic [NM*64-1:0]  m_di;
   logic [63:0]       m_do;
   logic [FD-1:0]     s_adr;
   logic              s_stb;
   logic              s_we;
   logic              s_eack;
   logic [7:0]        s_sel;
   logic [63:0]       s_di;
   logic [63:0]       s_do;

   int n_assert = 0;
   int n_fail   = 0;

   bit md_granted = 0;
   int md_owner   = 0;
   int md_wowner  = 0;
   int md_rrptr   = 0;

   always #5 sys_clk = ~sys_clk;

   fmlarb_ctl #(.nmasters(NM), .fml_depth(FD)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .m_adr     (m_adr),
      .m_stb     (m_stb),
      .m_we      (m_we),
      .m_eack    (m_eack),
      .m_sel     (m_sel),
      .m_di      (m_di),
      .m_do      (m_do),
      .s_adr     (s_adr),
      .s_stb     (s_stb),
      .s_we      (s_we),
      .s_eack    (s_eack),
      .s_sel     (s_sel),
      .s_di      (s_di),
      .s_do      (s_do)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [NM-1:0] req, input int start);
      for (int k = 0; k < NM; k++)
         if (req[(start + k) % NM]) return (start + k) % NM;
      return 0;
   endfunction

   // Check outputs mid-cycle, then advance the model across the rising edge.
   task automatic tick();
      logic [NM-1:0] e_eack;
      bit            act;
      #1;
      act = sys_rst_n && md_granted;
      check("s_stb", s_stb, act && m_stb[md_owner]);
      e_eack = '0;
      if (act) e_eack[md_owner] = s_eack;
      check("m_eack", m_eack, e_eack);
      if (act) begin
         check("s_adr", s_adr, m_adr[md_owner*FD +: FD]);
         check("s_we", s_we, m_we[md_owner]);
      end
      check("s_di", s_di, m_di[md_wowner*64 +: 64]);
      check("s_sel", s_sel, m_sel[md_wowner*8 +: 8]);
      check("m_do", m_do, s_do);
      @(posedge sys_clk);
      if (!sys_rst_n) begin
         md_granted = 0; md_owner = 0; md_wowner = 0; md_rrptr = 0;
      end else if (!md_granted) begin
         if (m_stb != '0) begin
`ifdef FMLARB_FIXED_PRIO_EN
            md_owner = pick(m_stb, 0);
`else
            md_owner = pick(m_stb, md_rrptr);
`endif
            md_granted = 1;
         end
      end else if (s_eack) begin
         md_granted = 0;
`ifdef FMLARB_FIXED_PRIO_EN
         md_rrptr = 0;
`else
         md_rrptr = (md_owner + 1) % NM;
`endif
         if (m_we[md_owner]) md_wowner = md_owner;
      end else if (!m_stb[md_owner]) begin
         md_granted = 0;
      end
      @(negedge sys_clk);
   endtask

   task automatic serve(input string tag);
      bit done = 0;
      for (int c = 0; c < 10 && !done; c++) begin
         #1;
         s_eack = s_stb;
         if (s_stb) done = 1;
         tick();
      end
      s_eack = 1'b0;
      m_stb  = '0;
      check(tag, done, 1'b1);
   endtask

   initial begin
      int got[$];
      int exp_order[5];
      int idx;
      logic [63:0] wdata;

`ifdef FMLARB_FIXED_PRIO_EN
      exp_order = '{0, 0, 0, 0, 0};
`else
      exp_order = '{0, 1, 2, 3, 0};
`endif
      sys_rst_n = 1'b0;
      m_stb = '1; m_we = '0; m_sel = '0; s_eack = 1'b1; s_do = '0;
      for (int i = 0; i < NM; i++) begin
         m_adr[i*FD +: FD] = FD'(32'h100 * (i + 1));
         m_di[i*64 +: 64]  = {32'hC0DE_0000, 32'(i)};
         m_sel[i*8 +: 8]   = 8'(8'h11 << i);
      end
      @(posedge sys_clk);
      @(negedge sys_clk);

      // Reset held with every master requesting and a stray ack.
      #1;
      check("rst_s_stb", s_stb, 1'b0);
      check("rst_m_eack", m_eack, '0);
      tick();
      tick();
      sys_rst_n = 1'b1;
      s_eack = 1'b0;
      tick();

      // All masters requesting: acks pulsed whenever the strobe is up.
      for (int c = 0; c < 30 && got.size() < 5; c++) begin
         #1;
         if (c == 0) check("rst_grant_m0", {s_stb, s_adr}, {1'b1, m_adr[0 +: FD]});
         s_eack = s_stb;
         #1;
         if (s_eack) begin
            idx = -1;
            for (int i = 0; i < NM; i++) if (m_eack[i]) idx = i;
            check("eack_onehot", $countones(m_eack), 1);
            got.push_back(idx);
         end
         tick();
      end
      s_eack = 1'b0;
      m_stb = '0;
      for (int i = 0; i < 5; i++)
         check("grant_order", (got.size() > i) ? got[i] : -1, exp_order[i]);
      tick();

      // Write from master 2, then a read from master 1 must not disturb write data.
      wdata = 64'hA5A5_0000_0000_0002;
      m_di[2*64 +: 64] = wdata;
      m_stb = 4'b0100; m_we = 4'b0100;
      serve("wr_ack_timeout");
      #1;
      check("wr_steer", s_di, wdata);
      tick();
      m_stb = 4'b0010; m_we = 4'b0000;
      serve("rd_ack_timeout");
      #1;
      check("wr_hold", s_di, wdata);
      tick();

      // Read data broadcast.
      s_do = 64'hDEAD_BEEF_0123_4567;
      #1;
      check("rd_bcast", m_do, 64'hDEAD_BEEF_0123_4567);
      tick();

      // Master 3 aborts; arbitration pointer must still favour master 2.
      m_stb = 4'b1000;
      tick();
      tick();
      m_stb = 4'b0000;
      tick();
      m_stb = 4'b1100;
      tick();
      #1;
      check("abort_next", {s_stb, s_adr}, {1'b1, m_adr[2*FD +: FD]});
      tick();
      m_stb = '0;
      tick();

      // Randomized traffic including occasional resets.
      for (int c = 0; c < 600; c++) begin
         sys_rst_n = ($urandom_range(0, 59) != 0);
         m_stb  = NM'($urandom);
         m_we   = NM'($urandom);
         s_eack = ($urandom_range(0, 2) == 0);
         s_do   = {$urandom, $urandom};
         for (int i = 0; i < NM; i++) begin
            m_adr[i*FD +: FD] = FD'($urandom);
            m_di[i*64 +: 64]  = {$urandom, $urandom};
            m_sel[i*8 +: 8]   = 8'($urandom);
         end
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
